// File: rtl/ariane_axi_pkg.sv
// Shared AXI adapter request types used by the cache subsystem.
package ariane_axi;

   typedef enum logic {
      SINGLE_REQ,
      CACHE_LINE_REQ
   } ad_req_t;

endpackage

// File: rtl/axi_adapter_arbiter_pkg.sv
// State encoding and pointer helpers for the AXI adapter arbiter.
package axi_adapter_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP
   } arb_state_e;

   // Modulo increment; port counts need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arb_pick
   import axi_adapter_arbiter_pkg::*;
#(
   parameter int N = 3,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      int c;
      c     = 0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         c = (int'(ptr) + i) % N;
         if (!valid && req[c]) begin
            valid = 1'b1;
            idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Round-robin arbiter sharing one axi_adapter port between NR_PORTS requesters,
// with a single outstanding transaction routed back to its owner.
module axi_adapter_arbiter
   import axi_adapter_arbiter_pkg::*;
#(
   parameter int NR_PORTS     = 3,
   parameter int DATA_WIDTH   = 256,
   parameter int AXI_ID_WIDTH = 10
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic [NR_PORTS-1:0]                             req_i,
   input  ariane_axi::ad_req_t [NR_PORTS-1:0]              type_i,
   input  logic [NR_PORTS-1:0][63:0]                       addr_i,
   input  logic [NR_PORTS-1:0]                             we_i,
   input  logic [NR_PORTS-1:0][DATA_WIDTH/64-1:0][63:0]    wdata_i,
   input  logic [NR_PORTS-1:0][DATA_WIDTH/64-1:0][7:0]     be_i,
   input  logic [NR_PORTS-1:0][1:0]                        size_i,
   input  logic [NR_PORTS-1:0][AXI_ID_WIDTH-1:0]           id_i,
   output logic [NR_PORTS-1:0]                             gnt_o,
   output logic [NR_PORTS-1:0]                             valid_o,
   output logic [DATA_WIDTH/64-1:0][63:0]                  rdata_o,
   output logic [AXI_ID_WIDTH-1:0]                         id_o,
   output logic [63:0]                                     critical_word_o,
   output logic [NR_PORTS-1:0]                             critical_word_valid_o,
   output logic                                            adp_req_o,
   output ariane_axi::ad_req_t                             adp_type_o,
   output logic [63:0]                                     adp_addr_o,
   output logic                                            adp_we_o,
   output logic [DATA_WIDTH/64-1:0][63:0]                  adp_wdata_o,
   output logic [DATA_WIDTH/64-1:0][7:0]                   adp_be_o,
   output logic [1:0]                                      adp_size_o,
   output logic [AXI_ID_WIDTH-1:0]                         adp_id_o,
   input  logic                                            adp_gnt_i,
   input  logic                                            adp_valid_i,
   input  logic [DATA_WIDTH/64-1:0][63:0]                  adp_rdata_i,
   input  logic [AXI_ID_WIDTH-1:0]                         adp_id_i,
   input  logic [63:0]                                     adp_critical_word_i,
   input  logic                                            adp_critical_word_valid_i
);

   localparam int SEL_W = $clog2(NR_PORTS);

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] rr_q, rr_d;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_valid;

   rr_arb_pick #(.N(NR_PORTS)) u_pick (
      .req   (req_i),
      .ptr   (rr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign adp_type_o  = type_i[sel_q];
   assign adp_addr_o  = addr_i[sel_q];
   assign adp_we_o    = we_i[sel_q];
   assign adp_wdata_o = wdata_i[sel_q];
   assign adp_be_o    = be_i[sel_q];
   assign adp_size_o  = size_i[sel_q];
   assign adp_id_o    = id_i[sel_q];

   assign rdata_o         = adp_rdata_i;
   assign id_o            = adp_id_i;
   assign critical_word_o = adp_critical_word_i;

   always_comb begin
      state_d               = state_q;
      sel_d                 = sel_q;
      rr_d                  = rr_q;
      gnt_o                 = '0;
      valid_o               = '0;
      critical_word_valid_o = '0;
      adp_req_o             = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               sel_d   = pick_idx;
               state_d = REQ;
            end
         end
         REQ: begin
            adp_req_o                    = 1'b1;
            critical_word_valid_o[sel_q] = adp_critical_word_valid_i;
            if (adp_gnt_i) begin
               gnt_o[sel_q] = 1'b1;
               state_d      = WAIT_RSP;
               // Adapter may complete in the very cycle it grants.
               if (adp_valid_i) begin
                  valid_o[sel_q] = 1'b1;
                  rr_d           = SEL_W'(wrap_inc(32'(sel_q), NR_PORTS));
                  state_d        = IDLE;
               end
            end
         end
         WAIT_RSP: begin
            critical_word_valid_o[sel_q] = adp_critical_word_valid_i;
            if (adp_valid_i) begin
               valid_o[sel_q] = 1'b1;
               rr_d           = SEL_W'(wrap_inc(32'(sel_q), NR_PORTS));
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
      end
   end

   a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == REQ) |-> req_i[sel_q])
      else $error("requester dropped req while its request is pending");

   a_no_idle_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == IDLE) |-> !adp_valid_i)
      else $error("adapter completion with no outstanding transaction");

endmodule
